// File: rtl/gpr_scoreboard.sv
// rtl/gpr_scoreboard.sv - per-register pending-write scoreboard that stalls decode on RAW hazards
module gpr_scoreboard #(
    parameter int CNT_W = 2,
    parameter int NREG  = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [31:0]     id_instr,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic            id_reg_write,
    input  logic [4:0]      id_num_write,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_num_write,
    input  logic            flush,
    output logic            stall,
    output logic            issue,
    output logic            pending_any,
    output logic [NREG-1:0] pending_mask,
    output logic            wb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt [1:NREG-1];
    logic             r_wb_err;

    logic [CNT_W-1:0] w_cnt [NREG];
    logic [4:0]       w_rs;
    logic [4:0]       w_rt;
    logic             w_haz_rs;
    logic             w_haz_rt;
    logic             w_sat;
    logic             w_inc;
    logic             w_dec;
    logic             w_err;
    logic [NREG-1:1]  w_inc_vec;
    logic [NREG-1:1]  w_dec_vec;
    logic             w_unused_instr;

    assign w_rs           = id_instr[25:21];
    assign w_rt           = id_instr[20:16];
    assign w_unused_instr = ^{id_instr[31:26], id_instr[15:0]};

    // Register 0 has no counter; present it as permanently idle.
    always_comb begin
        w_cnt[0] = '0;
        for (int i = 1; i < NREG; i++) begin
            w_cnt[i] = r_cnt[i];
        end
    end

    assign w_haz_rs = id_use_rs && (w_rs != 5'd0) && (w_cnt[w_rs] != '0);
    assign w_haz_rt = id_use_rt && (w_rt != 5'd0) && (w_cnt[w_rt] != '0);
    assign w_sat    = id_reg_write && (id_num_write != 5'd0) && (w_cnt[id_num_write] == CNT_MAX);

    assign stall = id_valid && (w_haz_rs || w_haz_rt || w_sat);
    assign issue = id_valid && !stall;

    assign w_inc = issue && id_reg_write && (id_num_write != 5'd0);
    assign w_dec = wb_reg_write && (wb_num_write != 5'd0) && (w_cnt[wb_num_write] != '0);
    assign w_err = wb_reg_write && (wb_num_write != 5'd0) && (w_cnt[wb_num_write] == '0);

    always_comb begin
        w_inc_vec = '0;
        w_dec_vec = '0;
        for (int i = 1; i < NREG; i++) begin
            w_inc_vec[i] = w_inc && (id_num_write == 5'(i));
            w_dec_vec[i] = w_dec && (wb_num_write == 5'(i));
        end
    end

    // Issue and retire of the same register in one cycle cancel out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NREG; i++) begin
                r_cnt[i] <= '0;
            end
            r_wb_err <= 1'b0;
        end else if (flush) begin
            for (int i = 1; i < NREG; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (w_inc_vec[i] && !w_dec_vec[i]) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end else if (w_dec_vec[i] && !w_inc_vec[i]) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
            if (w_err) begin
                r_wb_err <= 1'b1;
            end
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 1; i < NREG; i++) begin
            pending_mask[i] = (r_cnt[i] != '0);
        end
    end

    assign pending_any = |pending_mask;
    assign wb_err      = r_wb_err;

endmodule
